// File: rtl/updown_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl_if
// Groups the control and counter-loop signals of updown_sweep_ctrl.
//
// Handshake: `start` is a single-cycle request with no ready.
//   - It is accepted only in the cycle where the controller is idle.
//   - `busy` (registered) is the only back-pressure indication.
//   - Upstream must not assume acceptance unless `busy` or `cfg_err` follows
//     one cycle later.
//   - `stop` is level-sampled only while busy.
//
// Signals:
//   start, stop       upstream requests
//   lo, hi, cycles    sweep configuration, captured on an accepted start
//   cnt_in            counter output fed back
//   cnt_clr, cnt_up   counter controls (sync clear, direction 1=up)
//   busy              high in SEEK/UP/DOWN
//   done, aborted     single-cycle completion pulses
//   cfg_err           single-cycle pulse on a rejected start
//   periods           completed triangle periods
//
// Modports: master = upstream/counter side, slave = controller.
// -----------------------------------------------------------------------------
interface updown_sweep_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int PER_W = 8
);
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [PER_W-1:0] cycles;
   logic [WIDTH-1:0] cnt_in;
   logic             cnt_clr;
   logic             cnt_up;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             cfg_err;
   logic [PER_W-1:0] periods;

   modport master (
      output start, stop, lo, hi, cycles, cnt_in,
      input  cnt_clr, cnt_up, busy, done, aborted, cfg_err, periods
   );

   modport slave (
      input  start, stop, lo, hi, cycles, cnt_in,
      output cnt_clr, cnt_up, busy, done, aborted, cfg_err, periods
   );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
// Drives an 8-bit up/down counter so that its output sweeps a triangle between
// latched bounds lo..hi for a programmed number of periods (0 = continuous).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   bus        updown_sweep_ctrl_if.slave (see interface header)
//   dbg_state  current FSM state: 0 IDLE, 1 SEEK, 2 UP, 3 DOWN
//
// The interface instance must be built with the same WIDTH/PER_W as this module.
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
   parameter int WIDTH = 8,
   parameter int PER_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   updown_sweep_ctrl_if.slave     bus,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEEK = 2'd1,
      ST_UP   = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [PER_W-1:0] cyc_q, cyc_d;
   logic [PER_W-1:0] periods_q, periods_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cnt_clr;
   logic             cnt_up;
   logic [PER_W-1:0] per_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         cyc_q     <= '0;
         periods_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         cyc_q     <= cyc_d;
         periods_q <= periods_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // The counter moves on every edge, so the counter controls are decoded
   // combinationally from cnt_in: a turnaround issued in the cycle the counter
   // sits on a bound makes the next value step back off that bound.
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      cyc_d     = cyc_q;
      periods_d = periods_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      cfg_err_d = 1'b0;
      cnt_clr   = 1'b0;
      cnt_up    = 1'b0;
      // Saturating increment; only reachable at all-ones in continuous mode.
      per_inc   = (periods_q == '1) ? periods_q : periods_q + 1'b1;

      if (state_q == ST_IDLE) begin
         cnt_clr = 1'b1;
         // stop is not looked at here, so start+stop together starts a run.
         if (bus.start) begin
            lo_d  = bus.lo;
            hi_d  = bus.hi;
            cyc_d = bus.cycles;
            if (bus.lo >= bus.hi) begin
               cfg_err_d = 1'b1;
            end else begin
               periods_d = '0;
               state_d   = ST_SEEK;
            end
         end
      end else if (bus.stop) begin
         // Abort wins over any period completion in the same cycle.
         cnt_clr   = 1'b1;
         aborted_d = 1'b1;
         state_d   = ST_IDLE;
      end else begin
         case (state_q)
            ST_SEEK: begin
               cnt_up = 1'b1;
               if (bus.cnt_in == lo_q) state_d = ST_UP;
            end
            ST_UP: begin
               if (bus.cnt_in == hi_q) begin
                  state_d = ST_DOWN;
               end else begin
                  cnt_up = 1'b1;
               end
            end
            ST_DOWN: begin
               if (bus.cnt_in == lo_q) begin
                  periods_d = per_inc;
                  if ((cyc_q != '0) && (per_inc == cyc_q)) begin
                     cnt_clr = 1'b1;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     cnt_up  = 1'b1;
                     state_d = ST_UP;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.cnt_clr = cnt_clr;
   assign bus.cnt_up  = cnt_up;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;
   assign bus.cfg_err = cfg_err_q;
   assign bus.periods = periods_q;
   assign dbg_state   = state_q;

endmodule
